// File: rtl/delay_calibrator.sv
// Closed-loop latency probe: steps stim_out, then counts enable ticks until resp_in
// reaches threshold. The result is reported in measured_length, or timeout is raised.
module delay_calibrator #(
  parameter int                   MAX_LENGTH = 32,
  parameter int                   BIT_WIDTH  = 16,
  parameter logic [BIT_WIDTH-1:0] AMPLITUDE  = 16'h4000,
  localparam int                  ADDR_WIDTH = $clog2(MAX_LENGTH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  start,
  input  logic                  abort,
  input  logic [BIT_WIDTH-1:0]  threshold,
  input  logic [BIT_WIDTH-1:0]  resp_in,
  output logic [BIT_WIDTH-1:0]  stim_out,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [ADDR_WIDTH-1:0] measured_length
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MAX_LENGTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_MEAS, S_DONE} state_t;

  // Saturating tick counter: the top value is sticky, so the count can never wrap.
  function automatic logic [ADDR_WIDTH-1:0] sat_inc(input logic [ADDR_WIDTH-1:0] v);
    return (v == LAST) ? LAST : v + ONE;
  endfunction

  state_t                  r_state, w_nxt_state;
  logic [ADDR_WIDTH-1:0]   r_count, w_nxt_count;
  logic [BIT_WIDTH-1:0]    r_stim, w_nxt_stim;
  logic                    r_busy, w_nxt_busy;
  logic                    r_done, w_nxt_done;
  logic                    r_timeout, w_nxt_timeout;
  logic [ADDR_WIDTH-1:0]   r_len, w_nxt_len;

  logic signed [BIT_WIDTH-1:0] w_resp;
  logic signed [BIT_WIDTH-1:0] w_thr;
  logic                        w_below;
  logic [ADDR_WIDTH-1:0]       w_inc;

  assign w_resp  = resp_in;
  assign w_thr   = threshold;
  assign w_below = (w_resp < w_thr);
  assign w_inc   = sat_inc(r_count);

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_count   = r_count;
    w_nxt_stim    = r_stim;
    w_nxt_done    = r_done;
    w_nxt_timeout = r_timeout;
    w_nxt_len     = r_len;
    if (abort) begin
      w_nxt_state   = S_IDLE;
      w_nxt_count   = '0;
      w_nxt_stim    = '0;
      w_nxt_done    = 1'b0;
      w_nxt_timeout = 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            w_nxt_state   = S_SETTLE;
            w_nxt_count   = '0;
            w_nxt_done    = 1'b0;
            w_nxt_timeout = 1'b0;
          end
        end
        S_SETTLE: begin
          // Wait for the path to sit below threshold before launching the step.
          if (enable) begin
            if (w_below) begin
              w_nxt_stim  = AMPLITUDE;
              w_nxt_count = ONE;
              w_nxt_state = S_MEAS;
            end else begin
              w_nxt_count = w_inc;
              if (w_inc == LAST) begin
                w_nxt_timeout = 1'b1;
                w_nxt_state   = S_DONE;
              end
            end
          end
        end
        S_MEAS: begin
          // A crossing on the last count still wins over the timeout.
          if (enable) begin
            if (!w_below) begin
              w_nxt_len   = r_count;
              w_nxt_done  = 1'b1;
              w_nxt_stim  = '0;
              w_nxt_state = S_DONE;
            end else if (r_count == LAST) begin
              w_nxt_timeout = 1'b1;
              w_nxt_stim    = '0;
              w_nxt_state   = S_DONE;
            end else begin
              w_nxt_count = w_inc;
            end
          end
        end
        default: w_nxt_state = S_IDLE;
      endcase
    end
    w_nxt_busy = (w_nxt_state == S_SETTLE) || (w_nxt_state == S_MEAS);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_stim    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_len     <= '0;
    end else begin
      r_state   <= w_nxt_state;
      r_count   <= w_nxt_count;
      r_stim    <= w_nxt_stim;
      r_busy    <= w_nxt_busy;
      r_done    <= w_nxt_done;
      r_timeout <= w_nxt_timeout;
      r_len     <= w_nxt_len;
    end
  end

  assign stim_out        = r_stim;
  assign busy            = r_busy;
  assign done            = r_done;
  assign timeout         = r_timeout;
  assign measured_length = r_len;

endmodule
